// File: rtl/rsa_modexp.sv
// Bit-serial RSA modular exponentiation: right-to-left square-and-multiply over shift-add MODMUL.
// Define RSA_CONST_TIME_EN for key-independent latency (always W iterations, MUL_R always runs).
module rsa_modexp #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic [DATA_WIDTH-1:0] modulusin,
    input  logic [DATA_WIDTH-1:0] keyin,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  ready,
    output logic                  busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_CHECK,
        S_MUL_R,
        S_MUL_B,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  e_q, e_d;
    logic [W-1:0]  base_q, base_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W+1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  out_q, out_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
`ifdef RSA_CONST_TIME_EN
    logic [CW-1:0] it_q, it_d;
`endif

    logic [W+1:0] n_ext, p_sh, p_s1, p_nx;
    logic [W-1:0] product;
    logic         mm_last;
    logic         exp_done;

    // One MODMUL step: P <- 2P + (a_msb ? b : 0), then up to two conditional subtracts.
    always_comb begin
        n_ext   = {2'b00, n_q};
        p_sh    = (p_q << 1) + {2'b00, (a_q[W-1] ? b_q : '0)};
        p_s1    = (p_sh >= n_ext) ? p_sh - n_ext : p_sh;
        p_nx    = (p_s1 >= n_ext) ? p_s1 - n_ext : p_s1;
        product = p_nx[W-1:0];
        mm_last = (cnt_q == LAST);
`ifdef RSA_CONST_TIME_EN
        exp_done = (it_q == CW'(W));
`else
        exp_done = (e_q == '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        e_d     = e_q;
        base_d  = base_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ready_d = ready_q;
        busy_d  = busy_q;
`ifdef RSA_CONST_TIME_EN
        it_d    = it_q;
`endif
        if (state_q == S_REDUCE || state_q == S_MUL_R || state_q == S_MUL_B) begin
            p_d   = p_nx;
            a_d   = a_q << 1;
            cnt_d = cnt_q + CW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    n_d   = modulusin;
                    e_d   = keyin;
                    a_d   = datain;
                    b_d   = W'(1);
                    p_d   = '0;
                    cnt_d = '0;
                    // N < 2 detours through CHECK, which finishes with result = 0.
                    if (modulusin < W'(2)) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_REDUCE;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_REDUCE: begin
                if (mm_last) begin
                    base_d  = product;
                    res_d   = W'(1);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                p_d   = '0;
                cnt_d = '0;
                if (n_q < W'(2) || exp_done) begin
                    out_d   = res_q;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
`ifdef RSA_CONST_TIME_EN
                end else begin
`else
                end else if (e_q[0]) begin
`endif
                    a_d     = res_q;
                    b_d     = base_q;
                    state_d = S_MUL_R;
`ifndef RSA_CONST_TIME_EN
                end else begin
                    a_d     = base_q;
                    b_d     = base_q;
                    state_d = S_MUL_B;
`endif
                end
            end
            S_MUL_R: begin
                if (mm_last) begin
`ifdef RSA_CONST_TIME_EN
                    if (e_q[0]) begin
                        res_d = product;
                    end
`else
                    res_d = product;
`endif
                    a_d     = base_q;
                    b_d     = base_q;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = S_MUL_B;
                end
            end
            S_MUL_B: begin
                if (mm_last) begin
                    base_d  = product;
                    e_d     = e_q >> 1;
`ifdef RSA_CONST_TIME_EN
                    it_d    = it_q + CW'(1);
`endif
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            e_q     <= '0;
            base_q  <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RSA_CONST_TIME_EN
            it_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            e_q     <= e_d;
            base_q  <= base_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef RSA_CONST_TIME_EN
            it_q    <= it_d;
`endif
        end
    end

    assign dataout = out_q;
    assign ready   = ready_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp: vector table, random operands vs. arithmetic model,
// and hand sequences for reset abort, input scrambling and en held in DONE.
module tb_rsa_modexp;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] datain = '0;
    logic [W-1:0] modulusin = '0;
    logic [W-1:0] keyin = '0;
    logic [W-1:0] dataout;
    logic         ready;
    logic         busy;

    int n_pass = 0;
    int n_total = 0;

    rsa_modexp #(.DATA_WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .datain   (datain),
        .modulusin(modulusin),
        .keyin    (keyin),
        .dataout  (dataout),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [31:0] ref_pow(input logic [31:0] d, input logic [31:0] e,
                                            input logic [31:0] n);
        logic [63:0] r, b, m;
        if (n < 2) return 0;
        m = 64'(n);
        r = 1;
        b = 64'(d) % m;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [31:0] e, input logic [31:0] n);
        int bl, pc;
        if (n < 2) return 1;
`ifdef RSA_CONST_TIME_EN
        return W + (W + 1) + 2 * W * W;
`else
        bl = 0;
        pc = 0;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) begin
                bl = i + 1;
                pc++;
            end
        end
        return W + (bl + 1) + W * (bl + pc);
`endif
    endfunction

    task automatic run(input logic [31:0] d, input logic [31:0] n, input logic [31:0] e,
                       input bit scramble, output logic [31:0] out, output int lat,
                       output logic busy0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        datain    = d;
        modulusin = n;
        keyin     = e;
        en        = 1'b1;
        @(posedge clock);
        #1;
        en    = 1'b0;
        busy0 = busy;
        lat   = 0;
        while (!ready && lat < 3000) begin
            if (scramble) begin
                datain    = $urandom;
                modulusin = $urandom;
                keyin     = $urandom;
                en        = 1'($urandom_range(0, 1));
            end
            @(posedge clock);
            #1;
            lat++;
        end
        en  = 1'b0;
        out = dataout;
    endtask

    typedef struct {
        logic [31:0] d;
        logic [31:0] n;
        logic [31:0] e;
        logic [31:0] exp_out;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] out;
    int          lat;
    logic        busy0;
    logic [31:0] rd, rn, re;

    initial begin
        vecs[0] = '{32'd4,    32'd497,  32'd13,   32'd445};
        vecs[1] = '{32'd65,   32'd3233, 32'd17,   32'd2790};
        vecs[2] = '{32'd2790, 32'd3233, 32'd2753, 32'd65};
        vecs[3] = '{32'd5000, 32'd3233, 32'd1,    32'd1767};
        vecs[4] = '{32'd7,    32'd3233, 32'd0,    32'd1};
        vecs[5] = '{32'd123,  32'd1,    32'd5,    32'd0};
        vecs[6] = '{32'd123,  32'd0,    32'd5,    32'd0};

        repeat (3) @(negedge clock);
        check("reset_ready", ready, 0);
        check("reset_busy", busy, 0);
        check("reset_dataout", dataout, 0);

        foreach (vecs[i]) begin
            run(vecs[i].d, vecs[i].n, vecs[i].e, 1'b0, out, lat, busy0);
            check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d_lat", i), lat, ref_lat(vecs[i].e, vecs[i].n));
            check($sformatf("vec%0d_busy_done", i), busy, 0);
            if (vecs[i].n >= 2) check($sformatf("vec%0d_busy_start", i), busy0, 1);
        end

        // The textbook vector with its latency pinned as a literal.
        run(32'd4, 32'd497, 32'd13, 1'b0, out, lat, busy0);
`ifdef RSA_CONST_TIME_EN
        check("lat_4_13_497", lat, 2113);
`else
        check("lat_4_13_497", lat, 261);
`endif
        check("keyin0_lat", ref_lat(32'd0, 32'd3233), 33);

        // Asynchronous clear of a finished result.
        #2 reset = 1'b1;
        #1;
        check("async_clr_dataout", dataout, 0);
        check("async_clr_ready", ready, 0);
        @(negedge clock);
        reset = 1'b0;

        // Abort mid-operation, then a fresh run after release.
        @(negedge clock);
        datain = 32'd4; modulusin = 32'd497; keyin = 32'd13; en = 1'b1;
        @(posedge clock);
        #1 en = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        check("midop_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_dataout", dataout, 0);
        @(negedge clock);
        reset = 1'b0;
        run(32'd4, 32'd497, 32'd13, 1'b0, out, lat, busy0);
        check("after_abort_out", out, 445);
        check("after_abort_lat", lat, ref_lat(32'd13, 32'd497));

        // Inputs and en scrambled after acceptance, then en held high in DONE.
        run(32'd65, 32'd3233, 32'd17, 1'b1, out, lat, busy0);
        check("scramble_out", out, 2790);
        check("scramble_lat", lat, ref_lat(32'd17, 32'd3233));
        en = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("hold_en_ready", ready, 1);
        check("hold_en_dataout", dataout, 2790);
        check("hold_en_busy", busy, 0);
        en = 1'b0;

        for (int k = 0; k < 8; k++) begin
            rd = $urandom;
            rn = (k == 0) ? 32'hFFFF_FFFF : $urandom;
            re = (k < 4) ? 32'($urandom_range(0, 4095)) : $urandom;
            run(rd, rn, re, 1'b0, out, lat, busy0);
            check($sformatf("rand%0d_out", k), out, ref_pow(rd, re, rn));
            check($sformatf("rand%0d_lat", k), lat, ref_lat(re, rn));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
